// File: rtl/decode_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_div_pkg
//  Description : Shared FSM state type, default operand widths and latency
//                for the sequential signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIN0_W_DEF = 68;
    localparam int DIN1_W_DEF = 29;
    localparam int DOUT_W_DEF = 40;

    // Start-to-done latency in ce-qualified cycles for the default widths.
    localparam int LATENCY = DIN0_W_DEF + 2;

endpackage
`default_nettype wire

// File: rtl/decode_udiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : decode_udiv_step
//  Description : One restoring radix-2 iteration: shift in a dividend bit,
//                trial-subtract the divisor, keep or restore.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_udiv_step #(
    parameter int W = 29
)(
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] w_shift;

    assign w_shift = {rem_i, bit_i};
    assign q_o     = (w_shift >= {1'b0, dvs_i});
    // A successful subtraction always leaves a value below the divisor,
    // so the low W bits of the modular difference are exact.
    assign rem_o   = q_o ? (w_shift[W-1:0] - dvs_i) : w_shift[W-1:0];

endmodule
`default_nettype wire

// File: rtl/decode_sdiv_68s_29s_40_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decode_sdiv_68s_29s_40_seq
//  Description : Sequential signed divider (restoring, one bit per ce cycle).
//                Define DECODE_SDIV_SAT_EN to saturate overflowing quotients.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_sdiv_68s_29s_40_seq
    import decode_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W_DEF,
    parameter int din1_WIDTH = DIN1_W_DEF,
    parameter int dout_WIDTH = DOUT_W_DEF,
    parameter int NUM_STAGE  = din0_WIDTH + 2
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    // ID is an instance tag only; it contributes nothing to the width.
    localparam int CNT_W = $clog2(NUM_STAGE + 1) + (ID * 0);

    state_t                  state_q;
    logic [din0_WIDTH-1:0]   dvd_q;
    logic [din1_WIDTH-1:0]   dvs_q;
    logic [din1_WIDTH-1:0]   prem_q;
    logic                    s0_q;
    logic                    s1_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic [dout_WIDTH-1:0]   dout_q;
    logic [din1_WIDTH-1:0]   rem_q;
    logic                    ovf_q;
    logic                    dbz_q;

    logic [din0_WIDTH-1:0]   w_din0_mag;
    logic [din1_WIDTH-1:0]   w_din1_mag;
    logic [din1_WIDTH-1:0]   w_step_rem;
    logic                    w_step_q;
    logic                    w_neg;
    logic                    w_dbz;
    logic [din1_WIDTH-1:0]   w_rem_sgn;
    logic [dout_WIDTH-1:0]   w_dout;
    logic                    w_ovf;

    assign w_din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
    assign w_din1_mag = din1[din1_WIDTH-1] ? -din1 : din1;

    decode_udiv_step #(
        .W      (din1_WIDTH)
    ) u_step (
        .rem_i  (prem_q),
        .bit_i  (dvd_q[din0_WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (w_step_rem),
        .q_o    (w_step_q)
    );

    assign w_neg     = s0_q ^ s1_q;
    assign w_dbz     = ~|dvs_q;
    assign w_rem_sgn = s0_q ? -prem_q : prem_q;

`ifdef DECODE_SDIV_SAT_EN
    localparam int QW = din0_WIDTH + 1;

    logic [QW-1:0]          w_q_full;
    logic [QW-dout_WIDTH:0] w_q_hi;
    logic                   w_q_ovf;

    // One extra bit holds +2^(din0_WIDTH-1), e.g. the most-negative / -1 case.
    assign w_q_full = w_neg ? -{1'b0, dvd_q} : {1'b0, dvd_q};
    assign w_q_hi   = w_q_full[QW-1:dout_WIDTH-1];
    assign w_q_ovf  = ~((&w_q_hi) | (~|w_q_hi));
    assign w_dout   = w_q_ovf ? (w_neg ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                       : {1'b0, {(dout_WIDTH-1){1'b1}}})
                              : w_q_full[dout_WIDTH-1:0];
    assign w_ovf    = w_q_ovf;
`else
    logic [dout_WIDTH-1:0]  w_q_lo;

    assign w_q_lo = dvd_q[dout_WIDTH-1:0];
    assign w_dout = w_neg ? -w_q_lo : w_q_lo;
    assign w_ovf  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= w_din0_mag;
                        dvs_q   <= w_din1_mag;
                        s0_q    <= din0[din0_WIDTH-1];
                        s1_q    <= din1[din1_WIDTH-1];
                        prem_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    // Dividend register doubles as the quotient shift register.
                    dvd_q  <= {dvd_q[din0_WIDTH-2:0], w_step_q};
                    prem_q <= w_step_rem;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(din0_WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    dout_q  <= w_dbz ? '0 : w_dout;
                    rem_q   <= w_dbz ? '0 : w_rem_sgn;
                    ovf_q   <= ~w_dbz & w_ovf;
                    dbz_q   <= w_dbz;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;

endmodule
`default_nettype wire
